// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo datapath constants: functional-unit count, bus widths,
// functional-unit index map and the reserved "no producer" tag.
package tomasulo_pkg;

  localparam int NUM_FU  = 4;
  localparam int DATA_W  = 32;
  localparam int LABEL_W = 4;

  localparam int FU_ALU = 0;
  localparam int FU_MUL = 1;
  localparam int FU_DIV = 2;
  localparam int FU_LS  = 3;

  localparam logic [LABEL_W-1:0] LABEL_NONE = '0;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: grants the first asserted request found when
// scanning upward from the pointer, wrapping modulo N. Purely combinational
// so it can also serve the reservation-station issue selectors.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [IDX_W-1:0] w_pos;

  // Walk the requesters in priority order starting at the pointer; first hit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = IDX_W'((int'(i_ptr) + k) % N);
      if (!o_valid && i_req[w_pos]) begin
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
        o_valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among the functional units,
// registered one-cycle-later broadcast of the winning result, and a sticky
// flag for requests that carry the reserved label 0.
import tomasulo_pkg::*;

module cdb_arbiter #(
  parameter int NUM_FU  = tomasulo_pkg::NUM_FU,
  parameter int DATA_W  = tomasulo_pkg::DATA_W,
  parameter int LABEL_W = tomasulo_pkg::LABEL_W
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic [NUM_FU-1:0]         require,
  input  logic [NUM_FU*DATA_W-1:0]  data,
  input  logic [NUM_FU*LABEL_W-1:0] label,
  input  logic                      hold,
  output logic [NUM_FU-1:0]         requireAC,
  output logic                      BCEN,
  output logic [DATA_W-1:0]         BCdata,
  output logic [LABEL_W-1:0]        BClabel,
  output logic                      tag_err
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0]  w_valid;
  logic [NUM_FU-1:0]  w_zeroLabel;
  logic [NUM_FU-1:0]  w_req;
  logic [NUM_FU-1:0]  w_grant;
  logic [PTR_W-1:0]   w_idx;
  logic               w_any;
  logic [DATA_W-1:0]  w_selData;
  logic [LABEL_W-1:0] w_selLabel;

  logic [PTR_W-1:0]   r_rrPtr;
  logic               r_bcen;
  logic [DATA_W-1:0]  r_bcData;
  logic [LABEL_W-1:0] r_bcLabel;
  logic               r_tagErr;

  // Split each request into "grantable" (real tag) and "bad" (label 0, never granted).
  always_comb begin
    w_valid     = '0;
    w_zeroLabel = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (label[i*LABEL_W +: LABEL_W] == LABEL_W'(LABEL_NONE)) begin
        w_zeroLabel[i] = require[i];
      end else begin
        w_valid[i] = require[i];
      end
    end
  end

  // Reset and stall both suppress every grant, so the picker sees no requests.
  assign w_req = (RST || hold) ? '0 : w_valid;

  rr_pick #(
    .N     (NUM_FU),
    .IDX_W (PTR_W)
  ) u_pick (
    .i_req   (w_req),
    .i_ptr   (r_rrPtr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_any)
  );

  assign requireAC = w_grant;

  // Route the granted unit's result and tag toward the broadcast register.
  always_comb begin
    w_selData  = '0;
    w_selLabel = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (w_grant[i]) begin
        w_selData  = data[i*DATA_W +: DATA_W];
        w_selLabel = label[i*LABEL_W +: LABEL_W];
      end
    end
  end

  // Broadcast register, round-robin pointer advance and sticky bad-tag flag.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_rrPtr   <= '0;
      r_bcen    <= 1'b0;
      r_bcData  <= '0;
      r_bcLabel <= '0;
      r_tagErr  <= 1'b0;
    end else begin
      r_bcen <= w_any;
      if (w_any) begin
        r_bcData  <= w_selData;
        r_bcLabel <= w_selLabel;
        r_rrPtr   <= (w_idx == PTR_W'(NUM_FU - 1)) ? '0 : w_idx + PTR_W'(1);
      end
      if (|w_zeroLabel) begin
        r_tagErr <= 1'b1;
      end
    end
  end

  assign BCEN    = r_bcen;
  assign BCdata  = r_bcData;
  assign BClabel = r_bcLabel;
  assign tag_err = r_tagErr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios with hand-computed expectations,
// then randomized requesters obeying the accept handshake, all cross-checked
// every cycle against a behavioural round-robin model.
module tb_cdb_arbiter;

  localparam int NF = 4;
  localparam int DW = 32;
  localparam int LW = 4;

  logic              clk;
  logic              RST;
  logic [NF-1:0]     require;
  logic [NF*DW-1:0]  data;
  logic [NF*LW-1:0]  label;
  logic              hold;
  logic [NF-1:0]     requireAC;
  logic              BCEN;
  logic [DW-1:0]     BCdata;
  logic [LW-1:0]     BClabel;
  logic              tag_err;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  int            mPtr = 0;
  bit            mBcen = 1'b0;
  logic [DW-1:0] mData = '0;
  logic [LW-1:0] mLabel = '0;
  bit            mTagErr = 1'b0;
  logic [NF-1:0] mLastGrant = '0;
  int            mG;
  int            cmpG;

  cdb_arbiter dut (
    .clk       (clk),
    .RST       (RST),
    .require   (require),
    .data      (data),
    .label     (label),
    .hold      (hold),
    .requireAC (requireAC),
    .BCEN      (BCEN),
    .BCdata    (BCdata),
    .BClabel   (BClabel),
    .tag_err   (tag_err)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference choice: first unit, counting up from the pointer modulo NF, with a real tag.
  function automatic int modelPick();
    if (RST || hold) return -1;
    for (int k = 0; k < NF; k++) begin
      int u = (mPtr + k) % NF;
      if (require[u] && label[u*LW +: LW] != 0) return u;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit hld);
    RST  = rst;
    hold = hld;
  endtask

  task automatic setUnit(input int u, input bit req, input logic [DW-1:0] d, input logic [LW-1:0] l);
    require[u]          = req;
    data[u*DW +: DW]    = d;
    label[u*LW +: LW]   = l;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model state advances on each rising edge from the inputs seen there.
  always @(posedge clk) begin
    mG = modelPick();
    mLastGrant = '0;
    if (RST) begin
      mPtr = 0; mBcen = 0; mData = '0; mLabel = '0; mTagErr = 0;
    end else begin
      if (mG >= 0) begin
        mBcen  = 1;
        mData  = data[mG*DW +: DW];
        mLabel = label[mG*LW +: LW];
        mPtr   = (mG + 1) % NF;
        mLastGrant[mG] = 1'b1;
      end else begin
        mBcen = 0;
      end
      for (int i = 0; i < NF; i++)
        if (require[i] && label[i*LW +: LW] == 0) mTagErr = 1;
    end
  end

  // Every falling edge: DUT outputs must agree with the model.
  always @(negedge clk) begin
    if (checkEn) begin
      cmpG = modelPick();
      checkOutput("model requireAC", requireAC, (cmpG >= 0) ? (64'd1 << cmpG) : 64'd0);
      checkOutput("model BCEN", BCEN, mBcen);
      checkOutput("model BCdata", BCdata, mData);
      checkOutput("model BClabel", BClabel, mLabel);
      checkOutput("model tag_err", tag_err, mTagErr);
    end
  end

  logic [NF-1:0] expAc [5];
  logic [LW-1:0] expLab [5];

  initial begin
    require = '0; data = '0; label = '0;
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < NF; i++) setUnit(i, 1'b1, 32'hDEAD_0000 + i, LW'(i + 1));
    #2;
    checkOutput("ac during reset", requireAC, 4'b0000);
    cycle();
    checkEn = 1'b1;

    // Single alu request after reset.
    applyStimulus(1'b0, 1'b0);
    require = '0; data = '0; label = '0;
    setUnit(0, 1'b1, 32'h0000_0010, 4'h1);
    #2;
    checkOutput("reset BCEN", BCEN, 1'b0);
    checkOutput("reset BCdata", BCdata, 32'h0);
    checkOutput("reset BClabel", BClabel, 4'h0);
    checkOutput("reset tag_err", tag_err, 1'b0);
    checkOutput("alu ac", requireAC, 4'b0001);
    cycle();
    require = '0;
    checkOutput("alu BCEN", BCEN, 1'b1);
    checkOutput("alu BCdata", BCdata, 32'h10);
    checkOutput("alu BClabel", BClabel, 4'h1);
    #2;
    require = 4'b1111;
    for (int i = 0; i < NF; i++) setUnit(i, 1'b1, 32'hA000_0000 + i, LW'(4*i + 1));
    #1;
    checkOutput("ptr after alu", requireAC, 4'b0010);

    // All four continuously requesting from pointer 0.
    applyStimulus(1'b1, 1'b0);
    cycle();
    applyStimulus(1'b0, 1'b0);
    expAc[0] = 4'b0001; expAc[1] = 4'b0010; expAc[2] = 4'b0100; expAc[3] = 4'b1000; expAc[4] = 4'b0001;
    expLab[0] = 4'd1; expLab[1] = 4'd5; expLab[2] = 4'd9; expLab[3] = 4'd13; expLab[4] = 4'd1;
    for (int n = 0; n < 5; n++) begin
      #2;
      checkOutput("rr ac", requireAC, expAc[n]);
      cycle();
      checkOutput("rr BCEN", BCEN, 1'b1);
      checkOutput("rr BClabel", BClabel, expLab[n]);
    end

    // Wrap-around: pointer 2 with alu and mul requesting picks alu.
    require = 4'b0010;
    #2; checkOutput("mul ac", requireAC, 4'b0010);
    cycle();
    require = 4'b0011;
    #2; checkOutput("wrap ac", requireAC, 4'b0001);
    cycle();
    #2; checkOutput("ptr1 ac", requireAC, 4'b0010);
    cycle();

    // Hold for three cycles with mul waiting.
    require = '0;
    setUnit(1, 1'b1, 32'h1234_5678, 4'h7);
    applyStimulus(1'b0, 1'b1);
    for (int n = 0; n < 3; n++) begin
      #2; checkOutput("hold ac", requireAC, 4'b0000);
      cycle();
      checkOutput("hold BCEN", BCEN, 1'b0);
    end
    applyStimulus(1'b0, 1'b0);
    #2; checkOutput("post-hold ac", requireAC, 4'b0010);
    cycle();
    require = '0;
    checkOutput("post-hold BClabel", BClabel, 4'h7);
    checkOutput("post-hold BCdata", BCdata, 32'h1234_5678);

    // ls with label 0: never granted, sticky error.
    setUnit(3, 1'b1, 32'hBAD0_0000, 4'h0);
    #2; checkOutput("zero-label ac", requireAC, 4'b0000);
    cycle();
    checkOutput("zero-label tag_err", tag_err, 1'b1);
    checkOutput("zero-label BCEN", BCEN, 1'b0);
    require = '0;
    cycle(); cycle();
    checkOutput("tag_err sticky", tag_err, 1'b1);
    applyStimulus(1'b1, 1'b0);
    cycle();
    checkOutput("tag_err cleared", tag_err, 1'b0);

    // Reset during a grant cycle returns the pointer to 0.
    applyStimulus(1'b0, 1'b0);
    setUnit(2, 1'b1, 32'h3, 4'h3);
    cycle();
    require = '0;
    setUnit(0, 1'b1, 32'hAAAA_0000, 4'h2);
    setUnit(3, 1'b1, 32'hBBBB_0000, 4'h4);
    applyStimulus(1'b1, 1'b0);
    #2; checkOutput("rst-grant ac", requireAC, 4'b0000);
    cycle();
    checkOutput("rst-grant BCEN", BCEN, 1'b0);
    applyStimulus(1'b0, 1'b0);
    #2; checkOutput("after-rst ac", requireAC, 4'b0001);
    cycle();
    require[0] = 1'b0;
    checkOutput("after-rst BClabel", BClabel, 4'h2);
    #2; checkOutput("after-rst ls ac", requireAC, 4'b1000);
    cycle();
    require = '0;

    // Randomized requesters honouring the accept handshake.
    for (int c = 0; c < 3000; c++) begin
      cycle();
      for (int i = 0; i < NF; i++) begin
        if (mLastGrant[i] || !require[i]) begin
          if ($urandom_range(0, 9) < 6)
            setUnit(i, 1'b1, $urandom, ($urandom_range(0, 59) == 0) ? 4'h0 : LW'($urandom_range(1, 15)));
          else
            require[i] = 1'b0;
        end
      end
      applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0);
    end
    cycle();
    checkEn = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter and output register for the common data bus (CDB) shared by the four functional units: alu, mul, div and load/store. Each unit raises a request with its result and tag, and the arbiter grants one unit per cycle. The granted result is registered and broadcast one cycle later to every reservation station, queue and the register file. The block replaces the fixed-priority combinational CDB selector and removes its starvation problem.

## Interface
Parameters:
- NUM_FU, 4, number of requesters; index 0 alu, 1 mul, 2 div, 3 ls.
- DATA_W, 32, result width.
- LABEL_W, 4, tag width; tag 0 means "no producer" and is never broadcast.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- require  in  NUM_FU  per-unit request; must stay high with stable data/label until accepted.
- data  in  NUM_FU*DATA_W  per-unit result, unit i at bits [i*DATA_W +: DATA_W].
- label  in  NUM_FU*LABEL_W  per-unit tag, packed the same way.
- hold  in  1  stalls the bus; no grant is issued while high.
- requireAC  out  NUM_FU  one-hot accept, combinational in the request cycle.
- BCEN  out  1  broadcast valid, registered.
- BCdata  out  DATA_W  broadcast data, registered.
- BClabel  out  LABEL_W  broadcast tag, registered.
- tag_err  out  1  sticky flag: a request carried label 0.

## Operation
- State:
  - rr_ptr (log2 NUM_FU bits): index of the highest-priority requester.
  - Broadcast register: BCEN, BCdata, BClabel.
  - tag_err.
- Valid request for unit i: require[i] && label_i != 0.
- A request with label 0 is never granted. It sets tag_err, which clears only on RST.
- Grant selection, when hold == 0: scan from rr_ptr upward, modulo NUM_FU. The first valid request gets requireAC[i] = 1. At most one bit of requireAC is high.
- When hold == 1 or there is no valid request:
  - requireAC is all zero.
  - rr_ptr is unchanged.
  - BCEN is 0 on the next cycle.
- On a grant to unit g:
  - Next cycle: BCEN = 1, BCdata = data_g, BClabel = label_g.
  - rr_ptr becomes (g + 1) mod NUM_FU.
- When BCEN = 0, BCdata and BClabel hold their previous values. Consumers qualify them with BCEN.
- Requester handshake: a unit that sees requireAC[i] high at a clock edge treats the result as consumed. In the next cycle it either drops require or presents a new result.
- Fairness: with all units requesting continuously, each unit is granted exactly once in every NUM_FU consecutive cycles.
- Requests arriving while hold is high are serviced after hold falls, in round-robin order from the current rr_ptr.

## Timing
- Reset values: rr_ptr = 0, BCEN = 0, BCdata = 0, BClabel = 0, tag_err = 0. requireAC = 0 during the reset cycle regardless of require.
- Grant latency: 0 cycles, since requireAC is combinational from require, label, hold and rr_ptr.
- Broadcast latency: 1 cycle from the grant cycle to BCEN.
- Throughput: one broadcast per cycle.
- Combinational path: require to requireAC. There is no path from requireAC back into require inside the block.
- Reset while a request is pending: the grant is dropped, rr_ptr returns to 0, and BCEN stays 0. The requester keeps require high and is re-arbitrated after reset.
- Simultaneous RST and hold: reset wins.
- rr_ptr wraps from NUM_FU-1 to 0.

## Structure
- Shared package tomasulo_pkg holds:
  - NUM_FU, DATA_W, LABEL_W.
  - FU index constants FU_ALU = 0, FU_MUL = 1, FU_DIV = 2, FU_LS = 3.
  - LABEL_NONE = 0.
- Sub-module rr_pick: purely combinational rotating priority encoder. Inputs are a request vector and the pointer; outputs are a one-hot grant and an encoded index. It is reusable for the reservation-station issue selectors.
- cdb_arbiter itself holds rr_ptr, the broadcast register and tag_err.

## Test plan
- Reset, then require = 4'b0001 with alu data = 32'h0000_0010 and label = 4'h1 -> same cycle requireAC = 4'b0001; next cycle BCEN = 1, BCdata = 32'h10, BClabel = 1; rr_ptr = 1.
- All four units requesting continuously with labels 1, 5, 9, 13 -> grant order alu, mul, div, ls, alu; BClabel sequence 1, 5, 9, 13, 1; no unit waits more than 3 cycles.
- rr_ptr = 2, require = 4'b0011 -> alu granted (wrap-around), rr_ptr becomes 1.
- hold high for 3 cycles with mul requesting -> requireAC = 0 and BCEN = 0 throughout; first cycle after hold falls, mul is granted.
- ls requests with label 0 -> never granted; tag_err rises and stays high until RST.
- RST asserted in a grant cycle -> next cycle BCEN = 0 and rr_ptr = 0; the pending requester is granted in the first cycle after RST falls.
